audio_frame_scheduler: RTL and testbench



---
 rtl/audio_sched_pkg.sv | 25 ++
 rtl/audio_frame_scheduler_sample_fifo.sv | 58 +++++
 rtl/audio_frame_scheduler.sv | 154 +++++++++++++++
 tb/tb_audio_frame_scheduler.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/audio_sched_pkg.sv
// rtl/audio_sched_pkg.sv - shared types, constants and saturation helper for the audio frame scheduler
package audio_sched_pkg;

    localparam int SAMPLE_W = 16;
    localparam logic [SAMPLE_W-1:0] SAT_MAX = 16'h7FFF;
    localparam logic [SAMPLE_W-1:0] SAT_MIN = 16'h8000;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        FETCH,
        MIX,
        OUT
    } sched_state_t;

    // Clamp a 17-bit signed sum to the 16-bit signed range. The sum overflowed
    // exactly when its two top bits disagree; the top bit gives the direction.
    function automatic logic [SAMPLE_W-1:0] saturate(input logic [SAMPLE_W:0] sum);
        if (sum[SAMPLE_W] != sum[SAMPLE_W-1]) begin
            return sum[SAMPLE_W] ? SAT_MIN : SAT_MAX;
        end
        return sum[SAMPLE_W-1:0];
    endfunction

endpackage

// File: rtl/audio_frame_scheduler_sample_fifo.sv
// rtl/audio_frame_scheduler_sample_fifo.sv - synchronous sample FIFO with flush
//
// Ports:
//   clk, reset   system clock, synchronous active-high reset
//   flush        empties the FIFO on the next edge (takes priority over push/pop)
//   push, din    write din when not full
//   pop          advance the read pointer when not empty
//   dout         current head entry (combinational read)
//   full, empty  status from the extra pointer MSB
module sample_fifo
    import audio_sched_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = SAMPLE_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one wrap bit: equal pointers mean empty, equal index
    // with differing wrap bit means full.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push & ~full & ~flush & ~reset;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/audio_frame_scheduler.sv
// rtl/audio_frame_scheduler.sv - mixes two buffered sample sources into one audio word per LRCK frame
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   enable                0 = mute, flush FIFOs and idle
//   aud_lrck              asynchronous LRCK; rising edge starts a frame update
//   s0_data/valid/ready   source 0 (tone synth) sample stream
//   s1_data/valid/ready   source 1 (playback) sample stream
//   gain0, gain1          arithmetic right-shift per source
//   audiodata             saturated mix, held for the whole frame
//   frame_tick            1-cycle pulse when audiodata updates
//   underrun              per-source pulse: FIFO empty at frame fetch
//   under_cnt0/1          saturating underrun counters (AUDIO_SCHED_STATS_EN only)
module audio_frame_scheduler
    import audio_sched_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                aud_lrck,
    input  logic [SAMPLE_W-1:0] s0_data,
    input  logic                s0_valid,
    output logic                s0_ready,
    input  logic [SAMPLE_W-1:0] s1_data,
    input  logic                s1_valid,
    output logic                s1_ready,
    input  logic [2:0]          gain0,
    input  logic [2:0]          gain1,
    output logic [SAMPLE_W-1:0] audiodata,
    output logic                frame_tick,
    output logic [1:0]          underrun
`ifdef AUDIO_SCHED_STATS_EN
    ,
    output logic [15:0]         under_cnt0,
    output logic [15:0]         under_cnt1
`endif
);

    sched_state_t         state;
    logic [SYNC_STAGES-1:0] lrck_sync;
    logic                 lrck_prev;
    logic                 lrck_rise;
    logic [SAMPLE_W-1:0]  last0;
    logic [SAMPLE_W-1:0]  last1;
    logic [SAMPLE_W:0]    sum_q;
    logic [SAMPLE_W:0]    sum_next;
    logic signed [SAMPLE_W-1:0] a0;
    logic signed [SAMPLE_W-1:0] a1;
    logic [SAMPLE_W-1:0]  f0_dout;
    logic [SAMPLE_W-1:0]  f1_dout;
    logic                 f0_full, f0_empty, f1_full, f1_empty;
    logic                 fifo_flush;

    assign fifo_flush = ~enable;
    assign s0_ready   = enable & ~reset & ~f0_full;
    assign s1_ready   = enable & ~reset & ~f1_full;

    // The edge register keeps tracking LRCK even while idle so that enabling
    // mid-frame (LRCK already high) never produces a spurious rise.
    assign lrck_rise = lrck_sync[SYNC_STAGES-1] & ~lrck_prev;

    assign a0       = $signed(last0) >>> gain0;
    assign a1       = $signed(last1) >>> gain1;
    assign sum_next = {a0[SAMPLE_W-1], a0} + {a1[SAMPLE_W-1], a1};

    sample_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(SAMPLE_W)) u_fifo0 (
        .clk   (clk),
        .reset (reset),
        .flush (fifo_flush),
        .push  (s0_valid & s0_ready),
        .din   (s0_data),
        .pop   ((state == FETCH) & ~f0_empty),
        .dout  (f0_dout),
        .full  (f0_full),
        .empty (f0_empty)
    );

    sample_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(SAMPLE_W)) u_fifo1 (
        .clk   (clk),
        .reset (reset),
        .flush (fifo_flush),
        .push  (s1_valid & s1_ready),
        .din   (s1_data),
        .pop   ((state == FETCH) & ~f1_empty),
        .dout  (f1_dout),
        .full  (f1_full),
        .empty (f1_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            lrck_sync  <= '0;
            lrck_prev  <= 1'b0;
            last0      <= '0;
            last1      <= '0;
            sum_q      <= '0;
            audiodata  <= '0;
            frame_tick <= 1'b0;
            underrun   <= 2'b00;
        end else begin
            lrck_sync  <= {lrck_sync[SYNC_STAGES-2:0], aud_lrck};
            lrck_prev  <= lrck_sync[SYNC_STAGES-1];
            frame_tick <= 1'b0;
            underrun   <= 2'b00;
            if (!enable) begin
                // Abandon any frame in flight: no tick, muted output.
                state     <= IDLE;
                last0     <= '0;
                last1     <= '0;
                sum_q     <= '0;
                audiodata <= '0;
            end else begin
                case (state)
                    IDLE: state <= WAIT;
                    WAIT: if (lrck_rise) state <= FETCH;
                    FETCH: begin
                        // An empty source repeats its previous sample.
                        if (!f0_empty) last0 <= f0_dout;
                        if (!f1_empty) last1 <= f1_dout;
                        underrun <= {f1_empty, f0_empty};
                        state    <= MIX;
                    end
                    MIX: begin
                        sum_q <= sum_next;
                        state <= OUT;
                    end
                    OUT: begin
                        audiodata  <= saturate(sum_q);
                        frame_tick <= 1'b1;
                        state      <= WAIT;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef AUDIO_SCHED_STATS_EN
    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            under_cnt0 <= '0;
            under_cnt1 <= '0;
        end else begin
            if (underrun[0] && under_cnt0 != 16'hFFFF) under_cnt0 <= under_cnt0 + 16'd1;
            if (underrun[1] && under_cnt1 != 16'hFFFF) under_cnt1 <= under_cnt1 + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_audio_frame_scheduler.sv
// tb/tb_audio_frame_scheduler.sv - scoreboard testbench for audio_frame_scheduler
module tb_audio_frame_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        aud_lrck;
    logic [15:0] s0_data, s1_data;
    logic        s0_valid, s1_valid;
    logic        s0_ready, s1_ready;
    logic [2:0]  gain0, gain1;
    logic [15:0] audiodata;
    logic        frame_tick;
    logic [1:0]  underrun;
`ifdef AUDIO_SCHED_STATS_EN
    logic [15:0] under_cnt0, under_cnt1;
`endif

    audio_frame_scheduler dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .aud_lrck   (aud_lrck),
        .s0_data    (s0_data),
        .s0_valid   (s0_valid),
        .s0_ready   (s0_ready),
        .s1_data    (s1_data),
        .s1_valid   (s1_valid),
        .s1_ready   (s1_ready),
        .gain0      (gain0),
        .gain1      (gain1),
        .audiodata  (audiodata),
        .frame_tick (frame_tick),
        .underrun   (underrun)
`ifdef AUDIO_SCHED_STATS_EN
        ,
        .under_cnt0 (under_cnt0),
        .under_cnt1 (under_cnt1)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        logic [1:0]  und;
        int          rise;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    int          ticks = 0;
    int          nframes = 0;
    logic [1:0]  und_acc = 2'b00;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: collects underrun pulses across a frame and compares on each tick.
    always @(negedge clk) begin
        und_acc = und_acc | underrun;
        if (frame_tick === 1'b1) begin
            ticks++;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_frame_tick actual=1 required=0");
            end else begin
                mon_e = sb.pop_front();
                check("audiodata", {16'h0, audiodata}, {16'h0, mon_e.data});
                check("underrun", {30'h0, und_acc}, {30'h0, mon_e.und});
                check("latency", cyc - mon_e.rise, 6);
            end
            und_acc = 2'b00;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int src, input logic [15:0] d);
        int t;
        t = 0;
        if (src == 0) begin s0_data = d; s0_valid = 1'b1; end
        else          begin s1_data = d; s1_valid = 1'b1; end
        while (!((src == 0) ? s0_ready : s1_ready) && t < 50) begin
            step(1);
            t++;
        end
        if (t >= 50) begin
            checks++;
            failures++;
            $display("FAIL push_timeout actual=ready_low required=ready_high");
        end else begin
            step(1);
        end
        s0_valid = 1'b0;
        s1_valid = 1'b0;
    endtask

    task automatic frame(input logic [15:0] d, input logic [1:0] und);
        exp_t e;
        e.data = d;
        e.und  = und;
        e.rise = cyc;
        sb.push_back(e);
        nframes++;
        aud_lrck = 1'b1;
        step(10);
        aud_lrck = 1'b0;
        step(10);
    endtask

    initial begin
        int t;
        int t0;
        reset = 1'b1; enable = 1'b1; aud_lrck = 1'b0;
        s0_data = '0; s1_data = '0; s0_valid = 1'b0; s1_valid = 1'b0;
        gain0 = 3'd0; gain1 = 3'd0;
        step(3);
        check("reset_s0_ready", {31'h0, s0_ready}, 0);
        check("reset_s1_ready", {31'h0, s1_ready}, 0);
        check("reset_audiodata", {16'h0, audiodata}, 0);
        check("reset_frame_tick", {31'h0, frame_tick}, 0);
        check("reset_underrun", {30'h0, underrun}, 0);
        reset = 1'b0;
        step(2);
        check("ready_after_reset", {31'h0, s0_ready}, 1);

        push(0, 16'h1000); push(1, 16'h0200); frame(16'h1200, 2'b00);
        push(0, 16'h7000); push(1, 16'h7000); frame(16'h7FFF, 2'b00);
        push(0, 16'h8000); push(1, 16'hF000); frame(16'h8000, 2'b00);

        enable = 1'b0; step(1);
        check("disable_audiodata", {16'h0, audiodata}, 0);
        check("disable_s0_ready", {31'h0, s0_ready}, 0);
        enable = 1'b1; step(2);

        gain0 = 3'd4; push(0, 16'hF000); frame(16'hFF00, 2'b10); gain0 = 3'd0;

        for (int i = 1; i <= 4; i++) push(0, 16'(i * 16));
        check("full_ready", {31'h0, s0_ready}, 0);
        s0_data = 16'h0050; s0_valid = 1'b1;
        step(3);
        check("held_ready", {31'h0, s0_ready}, 0);
        s0_valid = 1'b0;
        frame(16'h0010, 2'b10);
        check("ready_after_frame", {31'h0, s0_ready}, 1);
        push(0, 16'h0050);
        check("refull_ready", {31'h0, s0_ready}, 0);
        for (int i = 2; i <= 5; i++) frame(16'(i * 16), 2'b10);

        enable = 1'b0; step(1); enable = 1'b1; step(2);
        push(1, 16'h0100);
        frame(16'h0100, 2'b01);
        frame(16'h0100, 2'b11);
`ifdef AUDIO_SCHED_STATS_EN
        check("under_cnt0", {16'h0, under_cnt0}, 2);
        check("under_cnt1", {16'h0, under_cnt1}, 1);
`endif

        push(0, 16'h1234); push(0, 16'h5678); push(1, 16'h0001);
        t0 = ticks;
        aud_lrck = 1'b1;
        step(4);
        enable = 1'b0;
        step(1);
        check("abort_audiodata", {16'h0, audiodata}, 0);
        check("abort_s0_ready", {31'h0, s0_ready}, 0);
        enable = 1'b1;
        step(8);
        check("no_tick_after_abort", ticks, t0);
        aud_lrck = 1'b0;
        step(10);
        check("no_tick_before_lrck", ticks, t0);
        frame(16'h0000, 2'b11);

        t = 0;
        while (sb.size() != 0 && t < 100) begin
            step(1);
            t++;
        end
        check("scoreboard_drained", sb.size(), 0);
        check("tick_count", ticks, nframes);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
